lab2_encoder_4x2_seq: RTL
=========================

LAB2_ENCODER_4X2_SEQ -- requirements
Module: lab2_encoder_4x2_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port enable, input, 1 bit: when 1, Din is sampled at the clk edge; when 0, Din is ignored.
REQ-004 The block SHALL have port Din, input, 4 bits: request lines; bit i high means event on line i (one-hot or multi-hot).
REQ-005 The block SHALL have port A, output, 2 bits: encoded index of the presented event; registered.
REQ-006 The block SHALL have port valid, output, 1 bit: A holds an unconsumed event; registered.
REQ-007 The block SHALL have port ready, input, 1 bit: consumer accepts A when valid and ready are both 1 at a clk edge.
REQ-008 The block SHALL have port pending, output, 4 bits: registered set of captured events not yet presented on A.

Function
REQ-009 The block SHALL form req = pending | (enable ? Din : 4'b0000) each cycle.
REQ-010 The output slot SHALL be free at an edge when valid==0 or (valid && ready).
REQ-011 At an edge with slot free and req!=0, the block SHALL load A with the selected index, set valid=1, and clear that bit from pending.
REQ-012 At an edge with slot free and req==0, the block SHALL set valid=0 and hold A.
REQ-013 At an edge with slot not free, the block SHALL hold A and valid and set pending = req.
REQ-014 On all loads, the unselected bits of req SHALL be written to pending.
REQ-015 Latency SHALL be one cycle: Din sampled with enable at edge k, free slot and no competing requests -> valid=1 and A=index after edge k.
REQ-016 With slot free, a handshake at edge k and req!=0 SHALL produce back-to-back output: valid stays 1 and A changes to the new index at edge k.
REQ-017 A request on a line already pending SHALL merge into one event; no count is kept.
REQ-018 A request on the line currently held in A (valid=1, not yet accepted) SHALL set its pending bit as a new, separate event.
REQ-019 Selection without the macro SHALL be fixed priority, with index 3 highest and 0 lowest.
REQ-020 A and valid SHALL be stable while valid=1 and ready=0.
REQ-021 ready while valid=0 SHALL have no effect.

Reset
REQ-022 While rst=1, the block SHALL force A=2'b00, valid=0, pending=4'b0000, and the round-robin pointer=2'b11, asynchronously and without waiting for clk.
REQ-023 Reset mid-operation SHALL discard the held and pending events; Din present at the first edge after rst falls SHALL be sampled normally.

Configuration
REQ-024 The block SHALL support the macro LAB2_ENC_ROUND_ROBIN_EN.
REQ-025 With LAB2_ENC_ROUND_ROBIN_EN defined, selection SHALL be round-robin: search starts at (last loaded index + 1) mod 4, ascending with wrap 3->0; the pointer updates on every load.
REQ-026 Without LAB2_ENC_ROUND_ROBIN_EN, the block SHALL use the fixed priority of REQ-019 and SHALL contain no pointer register.

Verification
REQ-027 Reset then single event: rst pulse; enable=1, Din=4'b0100 for one cycle, ready=1 -> A=2'b10, valid=1 for one cycle, then valid=0, pending=0000.
REQ-028 Enable gating: enable=0, Din=4'b1111 for 3 cycles -> valid stays 0 and pending stays 0000.
REQ-029 Multi-hot under fixed priority: Din=4'b1011 for one cycle, ready=1 -> A=11, then 01, then 00 on consecutive cycles; valid then falls.
REQ-030 Backpressure: Din=4'b0001 with ready=0 -> A=00 held with valid=1 for 5 cycles; Din=4'b0001 again during the stall -> pending=0001; raise ready -> A=00 presented twice in total.
REQ-031 Round-robin (macro defined): Din=4'b1111 held with ready=1 -> A sequence 00, 01, 10, 11, 00 ...; without the macro, the same stimulus -> A=11 repeated.
REQ-032 Reset mid-stream: pending=0110, valid=1; assert rst asynchronously between edges -> valid=0, A=00, and pending=0000 immediately, before the next clk edge.

Source files
------------

// File: rtl/lab2_encoder_4x2_seq.sv
// Sequential 4-to-2 encoder with a one-entry output slot and a pending-event set.
// Define LAB2_ENC_ROUND_ROBIN_EN for round-robin selection (default: fixed priority, 3 highest).
module lab2_encoder_4x2_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] Din,
    input  logic       ready,
    output logic [1:0] A,
    output logic       valid,
    output logic [3:0] pending
);
    logic [3:0] req;
    logic       free;
    logic       hit;
    logic [1:0] sel;

    assign req  = pending | (enable ? Din : 4'b0000);
    assign free = ~valid | ready;
    assign hit  = |req;

`ifdef LAB2_ENC_ROUND_ROBIN_EN
    logic [1:0] ptr;
    logic [1:0] idx;
    logic       found;

    // Search starts one past the last loaded index and wraps 3->0.
    always_comb begin
        sel   = 2'b00;
        idx   = 2'b00;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 2'b11;
        else if (free && hit)
            ptr <= sel;
    end
`else
    always_comb begin
        if (req[3])      sel = 2'd3;
        else if (req[2]) sel = 2'd2;
        else if (req[1]) sel = 2'd1;
        else             sel = 2'd0;
    end
`endif

    // A stalled slot still absorbs new requests, including one on the held line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A       <= 2'b00;
            valid   <= 1'b0;
            pending <= 4'b0000;
        end else if (free) begin
            if (hit) begin
                A       <= sel;
                valid   <= 1'b1;
                pending <= req & ~(4'b0001 << sel);
            end else begin
                valid   <= 1'b0;
                pending <= 4'b0000;
            end
        end else begin
            pending <= req;
        end
    end
endmodule
